// File: rtl/vx_gpu_pkg.sv
// Shared GPU definitions for the LSU commit path.
// Slot-index width derivation and the default commit payload type.
package vx_gpu_pkg;

    localparam int COMMIT_DATA_W = 128;

    // Lanes, tag and data are packed by the caller into one flat word.
    typedef logic [COMMIT_DATA_W-1:0] commit_data_t;

    function automatic int isw_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_lsu_gather_slot.sv
// One issue-slot sink: round-robin pick among requesting blocks,
// then a small FIFO presenting its head as the slot's commit.
module vx_lsu_gather_slot
    import vx_gpu_pkg::*;
#(
    parameter int NUM_BLOCKS = 2,
    parameter int DATA_W     = 128,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_BLOCKS-1:0]        req,
    input  logic [NUM_BLOCKS*DATA_W-1:0] req_data,
    output logic [NUM_BLOCKS-1:0]        grant,
    output logic                         valid,
    output logic [DATA_W-1:0]            data,
    input  logic                         ready
);

    localparam int BLK_W = isw_width(NUM_BLOCKS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BLK_W-1:0]  rr_ptr;
    logic [BLK_W-1:0]  win;
    logic              found;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [BLK_W-1:0] rr_idx(
        input logic [BLK_W-1:0] p,
        input int               i
    );
        return BLK_W'((int'(p) + i) % NUM_BLOCKS);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (!found && req[rr_idx(rr_ptr, i)]) begin
                found = 1'b1;
                win   = rr_idx(rr_ptr, i);
            end
        end
    end

    // Full check uses the registered count only, so ready never
    // depends on this cycle's downstream pop.
    always_comb begin
        push  = found && (count != CNT_W'(DEPTH)) && !reset;
        grant = '0;
        if (push) begin
            grant[win] = 1'b1;
        end
    end

    assign wr_data = req_data[win*DATA_W +: DATA_W];
    assign valid   = (count != '0);
    assign data    = mem[rd_ptr];
    assign pop     = valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (int'(win) == NUM_BLOCKS - 1) ? '0 : win + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/vx_lsu_commit_gather.sv
// Gathers commits from LSU blocks into per-issue-slot queues.
// Holds request decode, ready merge and the stall counter.
module vx_lsu_commit_gather
    import vx_gpu_pkg::*;
#(
    parameter int  NUM_BLOCKS  = 2,
    parameter int  ISSUE_WIDTH = 4,
    parameter int  DATA_W      = $bits(commit_data_t),
    parameter int  OUT_DEPTH   = 4,
    localparam int ISW_W       = isw_width(ISSUE_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BLOCKS-1:0]         in_valid,
    input  logic [NUM_BLOCKS*ISW_W-1:0]   in_isw,
    input  logic [NUM_BLOCKS*DATA_W-1:0]  in_data,
    output logic [NUM_BLOCKS-1:0]         in_ready,
    output logic [ISSUE_WIDTH-1:0]        out_valid,
    output logic [ISSUE_WIDTH*DATA_W-1:0] out_data,
    input  logic [ISSUE_WIDTH-1:0]        out_ready,
    output logic [31:0]                   perf_stalls
);

    logic [ISW_W-1:0]      isw   [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] req   [ISSUE_WIDTH];
    logic [NUM_BLOCKS-1:0] grant [ISSUE_WIDTH];
    logic                  stall;

    // Out-of-range slot indices match no slot, so such a block stalls.
    always_comb begin
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            isw[b] = in_isw[b*ISW_W +: ISW_W];
        end
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                req[s][b] = in_valid[b] && (isw[b] == ISW_W'(s));
            end
        end
    end

    for (genvar s = 0; s < ISSUE_WIDTH; s++) begin : g_slot
        vx_lsu_gather_slot #(
            .NUM_BLOCKS (NUM_BLOCKS),
            .DATA_W     (DATA_W),
            .DEPTH      (OUT_DEPTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .req      (req[s]),
            .req_data (in_data),
            .grant    (grant[s]),
            .valid    (out_valid[s]),
            .data     (out_data[s*DATA_W +: DATA_W]),
            .ready    (out_ready[s])
        );
    end

    always_comb begin
        in_ready = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            in_ready = in_ready | grant[s];
        end
    end

    assign stall = |(in_valid & ~in_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls <= '0;
        end else if (stall && (perf_stalls != '1)) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end

    for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_chk
        a_isw_range : assert property (
            @(posedge clk) disable iff (reset)
            in_valid[b] |-> ({1'b0, isw[b]} < (ISW_W+1)'(ISSUE_WIDTH))
        );
    end

endmodule

// File: tb/tb_vx_lsu_commit_gather.sv
// Scenario tasks plus a queue-based reference model for
// the LSU commit gather block.
module tb_vx_lsu_commit_gather;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   in_valid;
    logic [3:0]   in_isw;
    logic [255:0] in_data;
    logic [1:0]   in_ready;
    logic [3:0]   out_valid;
    logic [511:0] out_data;
    logic [3:0]   out_ready;
    logic [31:0]  perf_stalls;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per slot, plain RR index per slot.
    logic [127:0] mq [4][$];
    int           rr [4];
    longint       m_stalls;
    logic [1:0]   exp_ready;
    int           exp_win [4];
    logic [3:0]   exp_valid;

    always #5 clk = ~clk;

    vx_lsu_commit_gather dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_isw      (in_isw),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .perf_stalls (perf_stalls)
    );

    task automatic model_eval();
        exp_ready = '0;
        for (int s = 0; s < 4; s++) begin
            int first;
            first        = -1;
            exp_win[s]   = -1;
            exp_valid[s] = (mq[s].size() != 0);
            for (int k = 0; k < 2; k++) begin
                int b;
                b = (rr[s] + k) % 2;
                if (first < 0 && in_valid[b] && int'(in_isw[b*2 +: 2]) == s)
                    first = b;
            end
            if (!reset && first >= 0 && mq[s].size() < 4) begin
                exp_win[s]       = first;
                exp_ready[first] = 1'b1;
            end
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            for (int s = 0; s < 4; s++) begin
                mq[s].delete();
                rr[s] = 0;
            end
            m_stalls = 0;
        end else begin
            if (|(in_valid & ~exp_ready) && m_stalls < 64'hFFFFFFFF)
                m_stalls++;
            for (int s = 0; s < 4; s++) begin
                if (exp_valid[s] && out_ready[s])
                    void'(mq[s].pop_front());
                if (exp_win[s] >= 0) begin
                    mq[s].push_back(in_data[exp_win[s]*128 +: 128]);
                    rr[s] = (exp_win[s] + 1) % 2;
                end
            end
        end
    endtask

    task automatic tick();
        model_eval();
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_isw    = '0;
        in_data   = '0;
        out_ready = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 2'b11;
        in_isw   = '0;
        #1;
        n_cmp++;
        if (in_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ready got=%b want=00", in_ready);
        end
        tick();
        tick();
        reset    = 1'b0;
        in_valid = '0;
        #1;
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_valid got=%b want=0000", out_valid);
        end
        n_cmp++;
        if (perf_stalls !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_stalls got=%0d want=0", perf_stalls);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        out_ready          = 4'hF;
        in_valid           = 2'b01;
        in_isw             = 4'b0010;
        in_data[127:0]     = 128'hA5;
        #1;
        n_cmp++;
        if (in_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL single_ready got=%b want=01", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        n_cmp++;
        if (out_valid !== 4'b0100 || out_data[2*128 +: 128] !== 128'hA5) begin
            n_bad++;
            $display("FAIL single_out got=%b/%h want=0100/a5",
                     out_valid, out_data[2*128 +: 128]);
        end
        tick();
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_drain got=%b want=0000", out_valid);
        end
    endtask

    task automatic test_alternate();
        logic [127:0] prev;
        do_reset();
        out_ready = 4'hF;
        in_valid  = 2'b11;
        in_isw    = 4'b0000;
        prev      = '0;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] want;
            in_data[127:0]   = 128'h100 + 128'(i);
            in_data[255:128] = 128'h200 + 128'(i);
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_cmp++;
            if (in_ready !== want) begin
                n_bad++;
                $display("FAIL alt_grant[%0d] got=%b want=%b", i, in_ready, want);
            end
            if (i > 0) begin
                n_cmp++;
                if (out_valid[0] !== 1'b1 || out_data[127:0] !== prev) begin
                    n_bad++;
                    $display("FAIL alt_data[%0d] got=%b/%h want=1/%h",
                             i, out_valid[0], out_data[127:0], prev);
                end
            end
            prev = (i % 2 == 0) ? 128'h100 + 128'(i) : 128'h200 + 128'(i);
            tick();
        end
        in_valid = '0;
        #1;
        n_cmp++;
        if (perf_stalls !== 32'd6) begin
            n_bad++;
            $display("FAIL alt_stalls got=%0d want=6", perf_stalls);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int idx;
        int seq;
        do_reset();
        out_ready = 4'h0;
        in_isw    = 4'b0001;
        idx       = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid       = 2'b01;
            in_data[127:0] = 128'(idx);
            #1;
            n_cmp++;
            if (in_ready[0] !== (idx < 4)) begin
                n_bad++;
                $display("FAIL bp_fill[%0d] got=%b want=%b", c, in_ready[0], idx < 4);
            end
            if (in_ready[0] === 1'b1) idx++;
            tick();
        end
        in_data[127:0] = 128'(idx);
        #1;
        n_cmp++;
        if (perf_stalls !== 32'd4) begin
            n_bad++;
            $display("FAIL bp_stalls got=%0d want=4", perf_stalls);
        end
        out_ready = 4'b0010;
        n_cmp++;
        if (in_ready !== 2'b00 || out_valid[1] !== 1'b1 || out_data[255:128] !== 128'd0) begin
            n_bad++;
            $display("FAIL bp_nobypass got=%b/%b/%h want=00/1/0",
                     in_ready, out_valid[1], out_data[255:128]);
        end
        seq = 1;
        tick();
        out_ready = 4'h0;
        #1;
        n_cmp++;
        if (in_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_refill got=%b want=01", in_ready);
        end
        idx = 5;
        tick();
        in_data[127:0] = 128'(idx);
        #1;
        n_cmp++;
        if (in_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_full_again got=%b want=00", in_ready);
        end
        tick();
        out_ready = 4'hF;
        for (int c = 0; c < 20 && seq < 6; c++) begin
            in_valid       = (idx < 6) ? 2'b01 : 2'b00;
            in_data[127:0] = 128'(idx);
            #1;
            if (out_valid[1] === 1'b1) begin
                n_cmp++;
                if (out_data[255:128] !== 128'(seq)) begin
                    n_bad++;
                    $display("FAIL bp_order got=%0d want=%0d", out_data[255:128], seq);
                end
                seq++;
            end
            if (in_ready[0] === 1'b1) idx++;
            tick();
        end
        in_valid = '0;
        n_cmp++;
        if (seq != 6 || idx != 6) begin
            n_bad++;
            $display("FAIL bp_drain got=%0d/%0d want=6/6", seq, idx);
        end
    endtask

    task automatic test_parallel();
        do_reset();
        out_ready        = 4'hF;
        in_valid         = 2'b11;
        in_isw           = 4'b1100;
        in_data[127:0]   = 128'h11;
        in_data[255:128] = 128'h33;
        #1;
        n_cmp++;
        if (in_ready !== 2'b11) begin
            n_bad++;
            $display("FAIL par_ready got=%b want=11", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        n_cmp++;
        if (out_valid !== 4'b1001 || out_data[127:0] !== 128'h11 ||
            out_data[3*128 +: 128] !== 128'h33) begin
            n_bad++;
            $display("FAIL par_out got=%b/%h/%h want=1001/11/33",
                     out_valid, out_data[127:0], out_data[3*128 +: 128]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 4'h0;
        in_valid  = 2'b01;
        in_isw    = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            in_data[127:0] = 128'hD0 + 128'(i);
            tick();
        end
        in_valid = '0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 4'b0000 || perf_stalls !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_reset got=%b/%0d want=0000/0", out_valid, perf_stalls);
        end
        out_ready      = 4'hF;
        in_valid       = 2'b01;
        in_data[127:0] = 128'hBEEF;
        tick();
        in_valid = '0;
        #1;
        n_cmp++;
        if (out_valid !== 4'b0100 || out_data[2*128 +: 128] !== 128'hBEEF) begin
            n_bad++;
            $display("FAIL mid_after got=%b/%h want=0100/beef",
                     out_valid, out_data[2*128 +: 128]);
        end
        tick();
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_alone got=%b want=0000", out_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid = 2'($urandom);
            in_isw   = 4'($urandom);
            for (int w = 0; w < 8; w++) in_data[w*32 +: 32] = $urandom;
            out_ready = 4'($urandom | $urandom);
            model_eval();
            #1;
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL rnd_ready[%0d] got=%b want=%b", c, in_ready, exp_ready);
            end
            n_cmp++;
            if (out_valid !== exp_valid) begin
                n_bad++;
                $display("FAIL rnd_valid[%0d] got=%b want=%b", c, out_valid, exp_valid);
            end
            for (int s = 0; s < 4; s++) begin
                if (exp_valid[s]) begin
                    n_cmp++;
                    if (out_data[s*128 +: 128] !== mq[s][0]) begin
                        n_bad++;
                        $display("FAIL rnd_data[%0d][%0d] got=%h want=%h",
                                 c, s, out_data[s*128 +: 128], mq[s][0]);
                    end
                end
            end
            n_cmp++;
            if (perf_stalls !== 32'(m_stalls)) begin
                n_bad++;
                $display("FAIL rnd_stalls[%0d] got=%0d want=%0d", c, perf_stalls, m_stalls);
            end
            model_commit();
            @(negedge clk);
        end
        in_valid = '0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_isw    = '0;
        in_data   = '0;
        out_ready = '0;
        m_stalls  = 0;
        for (int s = 0; s < 4; s++) rr[s] = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_parallel();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vx_lsu_commit_gather.md
VX_LSU_COMMIT_GATHER -- requirements
Module: VX_lsu_commit_gather

Interface
REQ-001 Parameter NUM_BLOCKS, default 2: number of LSU block commit sources.
REQ-002 Parameter ISSUE_WIDTH, default 4: number of issue-slot commit sinks.
REQ-003 Parameter DATA_W, default 128: commit payload width (lanes, tag, data packed by caller).
REQ-004 Parameter OUT_DEPTH, default 4: per-slot output FIFO depth; power of two, >= 2.
REQ-005 Derived ISW_W = max(1, clog2(ISSUE_WIDTH)).
REQ-006 clk  input  1  clock; one clock domain, all logic on rising edge.
REQ-007 reset  input  1  reset; synchronous, active-high.
REQ-008 in_valid  input  NUM_BLOCKS  per-block commit request.
REQ-009 in_isw  input  NUM_BLOCKS*ISW_W  per-block target issue slot.
REQ-010 in_data  input  NUM_BLOCKS*DATA_W  per-block payload.
REQ-011 in_ready  output  NUM_BLOCKS  per-block accept.
REQ-012 out_valid  output  ISSUE_WIDTH  per-slot commit valid.
REQ-013 out_data  output  ISSUE_WIDTH*DATA_W  per-slot payload.
REQ-014 out_ready  input  ISSUE_WIDTH  per-slot sink accept.
REQ-015 perf_stalls  output  32  count of cycles with any in_valid & !in_ready.

Function
REQ-016 Input handshake completes on in_valid[b] & in_ready[b]; output on out_valid[s] & out_ready[s].
REQ-017 Any block may target any slot; requesters of slot s = {b : in_valid[b] & in_isw[b]==s}.
REQ-018 Per slot, round-robin arbiter grants at most one requester per cycle, only if FIFO count < OUT_DEPTH (no full-and-pop bypass; in_ready has no combinational dependence on out_ready).
REQ-019 in_ready[b] = 1 iff b is granted by slot in_isw[b]; at most one in_ready per slot per cycle.
REQ-020 RR pointer per slot: search starts at pointer; after grant to b, pointer <= (b+1) mod NUM_BLOCKS; unchanged when no grant.
REQ-021 Accepted payload written to slot FIFO tail; out_valid[s] = (count != 0), out_data[s] = FIFO head (registered).
REQ-022 Latency: payload accepted in cycle N appears on out_valid no earlier than N+1 (N+1 when FIFO empty).
REQ-023 Per-slot order preserved; per-block order preserved per slot.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance; read/write pointers wrap mod OUT_DEPTH.
REQ-025 in_isw >= ISSUE_WIDTH: request never granted (block stalls); simulation assertion fires.
REQ-026 perf_stalls increments by 1 per qualifying cycle, saturates at 32'hFFFFFFFF.
REQ-027 out_valid held with stable out_data until out_ready (no retraction).

Reset
REQ-028 While reset high: in_ready = 0; on the following cycle out_valid = 0.
REQ-029 Reset clears FIFO counts and pointers, RR pointers to 0, perf_stalls to 0.
REQ-030 Reset mid-operation discards all buffered commits; no output of pre-reset data after reset.

Structure
REQ-031 ISW_W derivation and commit payload packing typedef live in VX_gpu_pkg.
REQ-032 One sub-module VX_lsu_gather_slot (RR arbiter + FIFO + count), instantiated ISSUE_WIDTH times; top holds request decode, in_ready OR-reduction, perf counter.

Verification
REQ-033 Single block b0 -> slot 2, data 0xA5, out_ready=1: out_valid[2] one cycle after accept with 0xA5; other slots idle.
REQ-034 b0,b1 both -> slot 0 continuously, out_ready=1: grants alternate b0,b1,b0,... starting b0 after reset.
REQ-035 out_ready[1]=0, b0 sends 6 beats to slot 1 (OUT_DEPTH=4): 4 accepted, in_ready[0]=0 thereafter, perf_stalls increments per stalled cycle; release -> 0..5 emerge in order.
REQ-036 FIFO full, out_ready asserted with in_valid held: no push that cycle, push next cycle; count sequence 4,3,4.
REQ-037 b0->slot 0, b1->slot 3 same cycle: both accepted same cycle, both outputs valid next cycle.
REQ-038 Reset asserted with 3 entries buffered: out_valid=0 cycle after, perf_stalls=0, subsequent beat emerges alone.
